hdmi_timing_ctrl: RTL
=====================

// Module: hdmi_timing_ctrl
// PURPOSE
// - Video timing controller and pixel fetch sequencer for the HDMI path; sits between the pixel source and the three TMDS encoders.
// - Runs raster h/v counters, requests pixels PIX_LAT cycles ahead of display, and drives the per-pixel encoder inputs R/G/B_data, VDE and CD.
// - Start/stop is frame-aligned, so the sink never sees a truncated frame.
// PARAMETERS
// H_ACTIVE 640  visible pixels per line
// H_FP     16   h front porch (pixels)
// H_SYNC   96   hsync width (pixels)
// H_BP     48   h back porch (pixels); H_TOTAL = sum = 800
// V_ACTIVE 480  visible lines
// V_FP     10   v front porch (lines)
// V_SYNC   2    vsync width (lines)
// V_BP     33   v back porch (lines); V_TOTAL = sum = 525
// SYNC_POL 0    sync asserted level (0 = active-low)
// PIX_LAT  2    pixel source read latency, cycles; legal 1..4
// CW       12   width of counters and pix_x/pix_y
// PORTS
// pixclk      in  1   pixel clock; sole clock
// rst_n       in  1   asynchronous reset, active-low
// run         in  1   1 = generate video; 0 = stop at end of current frame
// busy        out 1   high whenever state != IDLE
// frame_start out 1   1-cycle pulse with pix_req for pixel (0,0)
// pix_req     out 1   pixel fetch strobe, active area only
// pix_x       out CW  fetch column, valid when pix_req
// pix_y       out CW  fetch row, valid when pix_req
// pix_r/g/b   in  8   source pixel, valid PIX_LAT cycles after pix_req
// R_data/G_data/B_data out 8  encoder pixel data; 0 when VDE = 0
// VDE         out 1   video data enable to encoders
// CD          out 2   {vsync, hsync} control data to encoders
// BEHAVIOUR
// - Reset (async, immediate, no clock needed): state IDLE, h=v=0, pix_req=0, frame_start=0, VDE=0, RGB=0, busy=0, CD={2{~SYNC_POL}}, delay pipes cleared.
// - FSM IDLE/RUN/DRAIN:
//   IDLE : counters held at 0; run=1 -> RUN next cycle, starting at h=0, v=0.
//   RUN  : run=0 -> DRAIN; counters keep running.
//   DRAIN: run=1 -> RUN, seamless, no counter disturbance; at h=H_TOTAL-1 and v=V_TOTAL-1 -> IDLE.
// - Counters: h counts 0..H_TOTAL-1, then wraps to 0 and v increments; v wraps to 0 after V_TOTAL-1. Next frame starts back-to-back.
// - frame_start pulses on every cycle in RUN/DRAIN with h=0, v=0.
// - Fetch timing:
//   pix_req = busy & h<H_ACTIVE & v<V_ACTIVE.
//   pix_x = h and pix_y = v, driven combinationally from the counters.
// - Sync:
//   hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
//   vsync asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, whole lines.
//   Asserted level = SYNC_POL; inactive = ~SYNC_POL, including in IDLE.
// - Alignment:
//   Active flag, syncs and x are delayed through a PIX_LAT-deep shift register.
//   pix_rgb is sampled in the cycle the delayed flag is high.
//   VDE, CD and RGB are registered together, so total latency is PIX_LAT+1 cycles.
//   pix_req at cycle t -> VDE=1 with that pixel at t+PIX_LAT+1.
// - Blanking: RGB forced to 0 whenever the delayed active flag is 0.
// - DRAIN completion: the final PIX_LAT+1 output cycles are V_BP blanking, so no flush logic is needed.
// - Pipes are cleared on entry to RUN from IDLE.
// - Reset mid-frame: all outputs return to reset values at once; the next run restarts at (0,0).
// CONFIGURATION
// - TEST_PATTERN_EN defined:
//   Adds input port tp_sel (1 bit).
//   tp_sel=1 ignores pix_r/g/b and outputs 8 vertical bars of width H_ACTIVE/8, using delayed x.
//   Bar order: white, yellow, cyan, green, magenta, red, blue, black; channels are 8'hFF or 8'h00.
//   pix_req is still driven; tp_sel is sampled per pixel.
// - TEST_PATTERN_EN undefined: tp_sel port absent; data always passes through.
// TESTING
// 1. Reset, run=0 for 1000 cycles -> busy=0, pix_req=0, VDE=0, RGB=0, CD=2'b11.
// 2. Defaults, run=1 -> frame_start every 420000 cycles; 640 pix_req per line over 480 lines.
//    Encoder-side CD[0] low 96 cycles starting at delayed h=656; CD[1] low on lines 490-491.
// 3. Source returns pix_r = pix_x[7:0] after 2 cycles -> VDE rises exactly 3 cycles after pix_req.
//    R_data = 0,1,2,...; VDE and RGB drop together.
// 4. run=0 at v=100 -> output continues through v=524, h=799; busy falls next cycle.
//    Re-raise run at v=300 instead -> next frame_start exactly 420000 cycles after the previous one.
// 5. rst_n low at v=200 mid-line -> VDE=0, CD=2'b11, busy=0 asynchronously; after release with run=1, the first fetch is (0,0).
// 6. TEST_PATTERN_EN, tp_sel=1 -> R/G/B = FF/FF/FF at x=0..79, FF/FF/00 at x=80..159, 00/00/00 at x=560..639.

Source files
------------

// File: rtl/hdmi_timing_ctrl.sv
// hdmi_timing_ctrl: raster timing generator and pixel fetch sequencer feeding
// the three TMDS encoders. Pixels are requested PIX_LAT cycles ahead of display.
// The active flag and the syncs travel through a matching delay pipe. The source
// pixel is then registered together with VDE and CD.
// Optional feature macro: TEST_PATTERN_EN. It adds the tp_sel input and an
// 8-bar colour pattern generator.
module hdmi_timing_ctrl #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   PIX_LAT  = 2,
    parameter int   CW       = 12
) (
    input  logic          pixclk,
    input  logic          rst_n,
    input  logic          run,
`ifdef TEST_PATTERN_EN
    input  logic          tp_sel,
`endif
    output logic          busy,
    output logic          frame_start,
    output logic          pix_req,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    input  logic [7:0]    pix_r,
    input  logic [7:0]    pix_g,
    input  logic [7:0]    pix_b,
    output logic [7:0]    R_data,
    output logic [7:0]    G_data,
    output logic [7:0]    B_data,
    output logic          VDE,
    output logic [1:0]    CD
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    // Per-pixel attributes carried alongside the source read latency.
    // The syncs are stored as "asserted" flags; polarity is applied at the output.
    typedef struct packed {
        logic          act;
        logic          hs;
        logic          vs;
`ifdef TEST_PATTERN_EN
        logic [CW-1:0] x;
`endif
    } pipe_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_h, r_v;
    pipe_t           r_pipe [PIX_LAT];
    pipe_t           w_pipe_in, w_d;
    logic            w_h_last, w_v_last, w_start;
    logic [7:0]      w_r, w_g, w_b;

    assign w_h_last = (r_h == CW'(H_TOTAL - 1));
    assign w_v_last = (r_v == CW'(V_TOTAL - 1));
    assign w_start  = (r_state == ST_IDLE) && run;

    assign busy        = (r_state != ST_IDLE);
    assign pix_x       = r_h;
    assign pix_y       = r_v;
    assign pix_req     = busy && (r_h < CW'(H_ACTIVE)) && (r_v < CW'(V_ACTIVE));
    assign frame_start = busy && (r_h == '0) && (r_v == '0);

    // Next-state logic: stopping only takes effect on the last pixel of a frame.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (run) w_state_nxt = ST_RUN;
            ST_RUN:   if (!run) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (run)                       w_state_nxt = ST_RUN;
                else if (w_h_last && w_v_last) w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Raster counters: held at 0 when idle; otherwise they free-run and wrap per frame.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_state == ST_IDLE) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    // Pipe input: the attributes of the pixel being requested this cycle.
    always_comb begin
        w_pipe_in     = '0;
        w_pipe_in.act = pix_req;
        w_pipe_in.hs  = busy && (r_h >= CW'(HS_START)) && (r_h < CW'(HS_END));
        w_pipe_in.vs  = busy && (r_v >= CW'(VS_START)) && (r_v < CW'(VS_END));
`ifdef TEST_PATTERN_EN
        w_pipe_in.x   = r_h;
`endif
    end

    // Delay pipe matching the source read latency. It is flushed when a new run starts.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIX_LAT; i++) r_pipe[i] <= '0;
        end else if (w_start) begin
            for (int i = 0; i < PIX_LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_pipe_in;
            for (int i = 1; i < PIX_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign w_d = r_pipe[PIX_LAT-1];

`ifdef TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    logic [2:0] w_bar;
    assign w_bar = 3'(w_d.x / CW'(BAR_W));
    // The bar order white, yellow, cyan, green, magenta, red, blue, black
    // maps onto the inverted bits of the bar index.
    always_comb begin
        w_r = pix_r;
        w_g = pix_g;
        w_b = pix_b;
        if (tp_sel) begin
            w_r = {8{~w_bar[1]}};
            w_g = {8{~w_bar[2]}};
            w_b = {8{~w_bar[0]}};
        end
    end
`else
    assign w_r = pix_r;
    assign w_g = pix_g;
    assign w_b = pix_b;
`endif

    // Encoder-side outputs are registered together. RGB is blanked outside the active area.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            VDE    <= 1'b0;
            CD     <= {2{~SYNC_POL}};
            R_data <= '0;
            G_data <= '0;
            B_data <= '0;
        end else begin
            VDE    <= w_d.act;
            CD     <= {w_d.vs ? SYNC_POL : ~SYNC_POL, w_d.hs ? SYNC_POL : ~SYNC_POL};
            R_data <= w_d.act ? w_r : 8'h00;
            G_data <= w_d.act ? w_g : 8'h00;
            B_data <= w_d.act ? w_b : 8'h00;
        end
    end

endmodule
